block_state_mem: RTL and testbench
==================================

// Module: block_state_mem
// PURPOSE
//  Brick-field state store for breakout; parametrised successor of the 1-bit brick map.
//  Each brick holds a HP_W-bit hit-point count (0 = destroyed).
//  Port A (collision logic) provides read/write plus an atomic "hit" decrement; port B (renderer) is read-only.
//  A fill sequencer (re)loads the whole field on reset or level start; a live-brick counter flags level clear.
// PARAMETERS
//  DEPTH   85  number of bricks (addresses 0..DEPTH-1)
//  ADDR_W  7   address width; 2**ADDR_W >= DEPTH
//  HP_W    2   hit-point bits per brick
//  INIT_HP 1   fill value applied after RESET
// PORTS
//  CLK             in   1        clock, all logic on posedge
//  RESET           in   1        synchronous, active-high
//  LOAD            in   1        start field fill with LOAD_HP (level start)
//  LOAD_HP         in   HP_W     fill value, sampled when LOAD=1
//  BUSY            out  1        fill in progress
//  A_ADDR          in   ADDR_W   port A address
//  A_WRITE_ENABLE  in   1        write A_IN to mem[A_ADDR]
//  A_IN            in   HP_W     write data
//  A_HIT           in   1        saturating decrement of mem[A_ADDR]
//  A_OUT           out  HP_W     value of mem[A_ADDR] before this cycle's op
//  B_ADDR          in   ADDR_W   renderer address
//  B_OUT           out  HP_W     registered read of mem[B_ADDR]
//  LIVE_COUNT      out  ADDR_W+1 number of entries != 0
//  CLEARED         out  1        one-cycle pulse when LIVE_COUNT reaches 0
// BEHAVIOUR
//  - Reset: A_OUT=0, B_OUT=0, LIVE_COUNT=0, CLEARED=0, BUSY=1, fill value=INIT_HP, FSM=FILL, ptr=0.
//  - FSM IDLE/FILL. FILL writes mem[ptr]<=fill value, one entry per cycle, ptr 0..DEPTH-1;
//    after the write to DEPTH-1: IDLE, BUSY=0. A fill takes exactly DEPTH cycles.
//  - LIVE_COUNT is reset to 0 on entering FILL and increments per nonzero fill write: it equals DEPTH
//    (or 0 for fill value 0) when BUSY falls.
//  - LOAD in IDLE: the next cycle is FILL with the latched LOAD_HP, ptr=0.
//    LOAD during FILL restarts from ptr=0 with the new value. RESET mid-fill also restarts.
//  - During FILL: port A ops are ignored, A_OUT=0. Port B reads stay live, so a partial field is visible.
//  - Port A (IDLE only), 1-cycle latency, read-first: A_OUT<=old mem[A_ADDR].
//    A_WRITE_ENABLE has priority over A_HIT. Hit: old!=0 -> old-1; old==0 -> unchanged (no wrap).
//  - LIVE_COUNT updates the cycle after an op: -1 on a nonzero->zero change, +1 on zero->nonzero, else held.
//  - CLEARED=1 for exactly one cycle, the cycle LIVE_COUNT becomes 0 in IDLE. Never asserted by a fill.
//  - A_ADDR or B_ADDR >= DEPTH: reads return 0; writes and hits are dropped (no count change).
//  - Port B is read-first: B_OUT<=old mem[B_ADDR] (1-cycle latency), including when A writes the same address.
// CONFIGURATION
//  BLOCK_STATE_FWD_EN defined: if B_ADDR==A_ADDR and port A modifies that entry this cycle,
//    B_OUT takes the new value (write-through forward to the renderer).
//  Undefined: pure read-first on B as above; B_OUT shows the new value one read later.
// TESTING
//  1 RESET 1 cycle, DEPTH=85, INIT_HP=1 -> BUSY high 85 cycles; then LIVE_COUNT=85; B reads of 0..84=1, of 100=0.
//  2 A_HIT addr 5 (HP=1) -> A_OUT=1, LIVE_COUNT 85->84; hit again -> A_OUT=0, mem stays 0, count stays 84.
//  3 LOAD with LOAD_HP=3, then A_HIT addr 7 twice -> A_OUT 3 then 2, mem[7]=1, LIVE_COUNT stays 85.
//  4 Hit every brick to 0 -> CLEARED pulses once as LIVE_COUNT hits 0; LOAD_HP=0 fill -> CLEARED stays 0.
//  5 LOAD at fill cycle 40 -> fill restarts at ptr 0, BUSY lasts 40+85 cycles; A_WRITE_ENABLE during fill ignored.
//  6 A_WRITE_ENABLE A_IN=2 plus B_ADDR on the same addr -> B_OUT=old value (new value with BLOCK_STATE_FWD_EN);
//    with A_HIT also asserted, the write wins.

Source files
------------

// File: rtl/block_state_mem.sv
// rtl/block_state_mem.sv - brick-field hit-point store with fill sequencer and live-brick counter
//
// Purpose:
//   Holds a HP_W-bit hit-point count per brick (0 = destroyed). Port A serves the
//   collision logic (read / write / saturating hit-decrement); port B serves the
//   renderer (read-only). A fill sequencer loads every entry after RESET or LOAD,
//   and LIVE_COUNT tracks the number of nonzero entries, pulsing CLEARED when it
//   reaches zero through port A activity.
//
// Configuration:
//   BLOCK_STATE_FWD_EN - when defined, a port B read of the address port A is
//   modifying this cycle returns the new value instead of the old one.
//
// Ports:
//   CLK            in   1         clock, all logic on posedge
//   RESET          in   1         synchronous, active-high
//   LOAD           in   1         start a field fill with LOAD_HP
//   LOAD_HP        in   HP_W      fill value, sampled with LOAD
//   BUSY           out  1         fill in progress
//   A_ADDR         in   ADDR_W    port A address
//   A_WRITE_ENABLE in   1         write A_IN to mem[A_ADDR]
//   A_IN           in   HP_W      port A write data
//   A_HIT          in   1         saturating decrement of mem[A_ADDR]
//   A_OUT          out  HP_W      mem[A_ADDR] before this cycle's op (registered)
//   B_ADDR         in   ADDR_W    renderer address
//   B_OUT          out  HP_W      registered read of mem[B_ADDR]
//   LIVE_COUNT     out  ADDR_W+1  number of nonzero entries
//   CLEARED        out  1         one-cycle pulse when LIVE_COUNT reaches 0 in IDLE

module block_state_mem #(
    parameter int DEPTH   = 85,
    parameter int ADDR_W  = 7,
    parameter int HP_W    = 2,
    parameter int INIT_HP = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD,
    input  logic [HP_W-1:0]   LOAD_HP,
    output logic              BUSY,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic              A_WRITE_ENABLE,
    input  logic [HP_W-1:0]   A_IN,
    input  logic              A_HIT,
    output logic [HP_W-1:0]   A_OUT,
    input  logic [ADDR_W-1:0] B_ADDR,
    output logic [HP_W-1:0]   B_OUT,
    output logic [ADDR_W:0]   LIVE_COUNT,
    output logic              CLEARED
);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [HP_W-1:0]   INIT_VAL = HP_W'(INIT_HP);

    logic [HP_W-1:0]   mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [HP_W-1:0]   fill_val;

    logic              a_valid;
    logic              b_valid;
    logic [HP_W-1:0]   a_old;
    logic [HP_W-1:0]   a_new;
    logic              a_mod;
    logic [HP_W-1:0]   b_next;

    always_comb begin
        a_valid = ({1'b0, A_ADDR} < DEPTH_W);
        b_valid = ({1'b0, B_ADDR} < DEPTH_W);

        // Out-of-range addresses read as 0 and never touch the array.
        a_old = '0;
        if (a_valid) begin
            a_old = mem[A_ADDR];
        end

        // Write wins over hit; a hit on a destroyed brick leaves it at 0.
        a_new = a_old;
        if (A_WRITE_ENABLE) begin
            a_new = A_IN;
        end else if (A_HIT && (a_old != '0)) begin
            a_new = a_old - 1'b1;
        end

        // Port A only acts in IDLE and yields to a LOAD arriving the same cycle.
        a_mod = (state == S_IDLE) && !LOAD && a_valid && (A_WRITE_ENABLE || A_HIT);

        b_next = '0;
        if (b_valid) begin
            b_next = mem[B_ADDR];
        end
`ifdef BLOCK_STATE_FWD_EN
        if (a_mod && (B_ADDR == A_ADDR)) begin
            b_next = a_new;
        end
`else
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_FILL;
            ptr        <= '0;
            fill_val   <= INIT_VAL;
            BUSY       <= 1'b1;
            A_OUT      <= '0;
            B_OUT      <= '0;
            LIVE_COUNT <= '0;
            CLEARED    <= 1'b0;
        end else begin
            // Port B stays live in both states so a partial fill is visible.
            B_OUT   <= b_next;
            CLEARED <= 1'b0;

            case (state)
                S_FILL: begin
                    A_OUT <= '0;
                    if (LOAD) begin
                        // Restart from the top with the new value; nothing is
                        // written on the restart cycle itself.
                        ptr        <= '0;
                        fill_val   <= LOAD_HP;
                        LIVE_COUNT <= '0;
                    end else begin
                        mem[ptr] <= fill_val;
                        if (fill_val != '0) begin
                            LIVE_COUNT <= LIVE_COUNT + 1'b1;
                        end
                        if (ptr == LAST_PTR) begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end

                S_IDLE: begin
                    if (LOAD) begin
                        state      <= S_FILL;
                        BUSY       <= 1'b1;
                        ptr        <= '0;
                        fill_val   <= LOAD_HP;
                        LIVE_COUNT <= '0;
                        A_OUT      <= '0;
                    end else begin
                        A_OUT <= a_old;
                        if (a_mod) begin
                            mem[A_ADDR] <= a_new;
                            if ((a_old != '0) && (a_new == '0)) begin
                                LIVE_COUNT <= LIVE_COUNT - 1'b1;
                                CLEARED    <= (LIVE_COUNT == (ADDR_W+1)'(1));
                            end else if ((a_old == '0) && (a_new != '0)) begin
                                LIVE_COUNT <= LIVE_COUNT + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= S_FILL;
                    ptr   <= '0;
                    BUSY  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_state_mem.sv
// tb/tb_block_state_mem.sv - directed scoreboard bench for block_state_mem

module tb_block_state_mem;

    localparam int DEPTH  = 85;
    localparam int ADDR_W = 7;
    localparam int HP_W   = 2;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              LOAD;
    logic [HP_W-1:0]   LOAD_HP;
    logic              BUSY;
    logic [ADDR_W-1:0] A_ADDR;
    logic              A_WRITE_ENABLE;
    logic [HP_W-1:0]   A_IN;
    logic              A_HIT;
    logic [HP_W-1:0]   A_OUT;
    logic [ADDR_W-1:0] B_ADDR;
    logic [HP_W-1:0]   B_OUT;
    logic [ADDR_W:0]   LIVE_COUNT;
    logic              CLEARED;

    block_state_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .HP_W   (HP_W),
        .INIT_HP(1)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .LOAD          (LOAD),
        .LOAD_HP       (LOAD_HP),
        .BUSY          (BUSY),
        .A_ADDR        (A_ADDR),
        .A_WRITE_ENABLE(A_WRITE_ENABLE),
        .A_IN          (A_IN),
        .A_HIT         (A_HIT),
        .A_OUT         (A_OUT),
        .B_ADDR        (B_ADDR),
        .B_OUT         (B_OUT),
        .LIVE_COUNT    (LIVE_COUNT),
        .CLEARED       (CLEARED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [HP_W-1:0] a;
        logic [HP_W-1:0] b;
        logic [ADDR_W:0] lc;
        logic            cl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m[DEPTH];
    int   m_lc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic a_op(input int addr, input int we, input int din, input int hit,
                        input int baddr, input string tag);
        int   old;
        int   nw;
        int   bexp;
        exp_t e;
        old  = (addr < DEPTH) ? m[addr] : 0;
        bexp = (baddr < DEPTH) ? m[baddr] : 0;
        nw   = old;
        if (we != 0) nw = din;
        else if (hit != 0 && old != 0) nw = old - 1;
`ifdef BLOCK_STATE_FWD_EN
        if (baddr == addr && addr < DEPTH && (we != 0 || hit != 0)) bexp = nw;
`else
`endif
        e.a  = HP_W'(old);
        e.b  = HP_W'(bexp);
        e.cl = 1'b0;
        if (addr < DEPTH) begin
            if (old != 0 && nw == 0) begin
                e.cl = (m_lc == 1);
                m_lc--;
            end else if (old == 0 && nw != 0) begin
                m_lc++;
            end
            m[addr] = nw;
        end
        e.lc = (ADDR_W+1)'(m_lc);
        sb.push_back(e);

        A_ADDR         = ADDR_W'(addr);
        A_WRITE_ENABLE = (we != 0);
        A_IN           = HP_W'(din);
        A_HIT          = (hit != 0);
        B_ADDR         = ADDR_W'(baddr);
        cyc();
        A_WRITE_ENABLE = 1'b0;
        A_HIT          = 1'b0;

        e = sb.pop_front();
        chk({tag, ".a_out"},      32'(A_OUT),      32'(e.a));
        chk({tag, ".b_out"},      32'(B_OUT),      32'(e.b));
        chk({tag, ".live_count"}, 32'(LIVE_COUNT), 32'(e.lc));
        chk({tag, ".cleared"},    32'(CLEARED),    32'(e.cl));
    endtask

    task automatic start_load(input int hp);
        LOAD    = 1'b1;
        LOAD_HP = HP_W'(hp);
        cyc();
        LOAD = 1'b0;
        for (int i = 0; i < DEPTH; i++) m[i] = hp;
        m_lc = (hp != 0) ? DEPTH : 0;
    endtask

    task automatic wait_fill(output int n, output int cl_seen);
        n       = 0;
        cl_seen = 0;
        while (BUSY === 1'b1 && n < 1000) begin
            n++;
            if (CLEARED === 1'b1) cl_seen++;
            cyc();
        end
    endtask

    initial begin
        int n;
        int cl_seen;
        int baddrs[4];

        RESET          = 1'b1;
        LOAD           = 1'b0;
        LOAD_HP        = '0;
        A_ADDR         = '0;
        A_WRITE_ENABLE = 1'b0;
        A_IN           = '0;
        A_HIT          = 1'b0;
        B_ADDR         = '0;

        // 1: reset state, fill length and initial contents
        cyc();
        chk("rst.busy",       32'(BUSY),       32'd1);
        chk("rst.a_out",      32'(A_OUT),      32'd0);
        chk("rst.b_out",      32'(B_OUT),      32'd0);
        chk("rst.live_count", 32'(LIVE_COUNT), 32'd0);
        chk("rst.cleared",    32'(CLEARED),    32'd0);
        RESET = 1'b0;
        for (int i = 0; i < DEPTH; i++) m[i] = 1;
        m_lc = DEPTH;
        wait_fill(n, cl_seen);
        chk("t1.fill_len",   32'(n),          32'd85);
        chk("t1.live_count", 32'(LIVE_COUNT), 32'd85);
        baddrs = '{0, 42, 84, 100};
        foreach (baddrs[i]) a_op(0, 0, 0, 0, baddrs[i], "t1.bread");

        // 2: hit a single-HP brick twice, second hit saturates at 0
        a_op(5, 0, 0, 1, 5, "t2.hit1");
        a_op(5, 0, 0, 1, 5, "t2.hit2");
        a_op(5, 0, 0, 0, 5, "t2.read");

        // 3: level with HP=3, two hits on one brick
        start_load(3);
        wait_fill(n, cl_seen);
        chk("t3.fill_len",   32'(n),          32'd85);
        chk("t3.live_count", 32'(LIVE_COUNT), 32'd85);
        a_op(7, 0, 0, 1, 7, "t3.hit1");
        a_op(7, 0, 0, 1, 7, "t3.hit2");
        a_op(7, 0, 0, 0, 7, "t3.read");

        // 4: destroy every brick, CLEARED on the last one only; zero fill never clears
        start_load(1);
        wait_fill(n, cl_seen);
        chk("t4.fill_len", 32'(n), 32'd85);
        for (int i = 0; i < DEPTH; i++) a_op(i, 0, 0, 1, i, "t4.hit");
        a_op(0, 0, 0, 0, 0, "t4.after");
        start_load(0);
        wait_fill(n, cl_seen);
        chk("t4.zero_fill_len",     32'(n),          32'd85);
        chk("t4.zero_fill_cleared", 32'(cl_seen),    32'd0);
        chk("t4.zero_live_count",   32'(LIVE_COUNT), 32'd0);
        chk("t4.zero_cleared_end",  32'(CLEARED),    32'd0);

        // 5: LOAD after 40 fill cycles restarts; port A activity during fill ignored
        LOAD    = 1'b1;
        LOAD_HP = 2'd2;
        cyc();
        LOAD = 1'b0;
        n    = 0;
        while (BUSY === 1'b1 && n < 1000) begin
            n++;
            if (n == 40) begin
                LOAD           = 1'b1;
                LOAD_HP        = 2'd1;
                A_ADDR         = '0;
                A_IN           = 2'd3;
                A_WRITE_ENABLE = 1'b1;
                A_HIT          = 1'b1;
            end
            if (n == 41) LOAD = 1'b0;
            if (n == 60) chk("t5.a_out_fill", 32'(A_OUT), 32'd0);
            cyc();
        end
        A_WRITE_ENABLE = 1'b0;
        A_HIT          = 1'b0;
        for (int i = 0; i < DEPTH; i++) m[i] = 1;
        m_lc = DEPTH;
        chk("t5.fill_len",   32'(n),          32'd125);
        chk("t5.live_count", 32'(LIVE_COUNT), 32'd85);
        a_op(1, 0, 0, 0, 0, "t5.bread0");

        // 6: write + hit + same-address renderer read; out-of-range accesses
        a_op(10, 1, 2, 1, 10, "t6.wr_hit");
        a_op(10, 0, 0, 1, 10, "t6.hit");
        a_op(100, 1, 0, 0, 100, "t6.oor_wr");
        a_op(100, 0, 0, 1, 100, "t6.oor_hit");
        a_op(10, 0, 0, 0, 10, "t6.read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
